// File: rtl/ifu32_pkg.sv
// ifu32_pkg: FSM state encodings, PC step and default reset PC shared by the fetch unit
package ifu32_pkg;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DROP, S_HALT} state_e;
  localparam int PC_STEP = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
endpackage

// File: rtl/ifu32_fifo.sv
// ifu32_fifo: DEPTH-entry sync FIFO (clk, rst async, flush, push/din, pop/dout, count); flush beats push and pop
module ifu32_fifo #(
  parameter int DW = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DW-1:0]            din,
  input  logic                     pop,
  output logic [DW-1:0]            dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    do_pop = pop && !flush && cnt_q != '0;
    do_push = push && !flush && (cnt_q != FULL || do_pop);
    wr_d = flush ? '0 : wr_q + PW'(do_push);
    rd_d = flush ? '0 : rd_q + PW'(do_pop);
    cnt_d = flush ? '0 : cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
  assign dout = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/ifu32.sv
// ifu32: RV32 fetch unit; PC + single-outstanding imem reads into a DEPTH-entry queue feeding decode.
// Ports: clk, rst (async, high); imem_req_{valid,ready,addr}; imem_rsp_{valid,data,err};
//        redirect_{valid,pc}; inst_{valid,ready}, inst, inst_pc; fetch_fault (sticky).
// Build option IFU32_ALIGN_CHECK_EN: misaligned redirect faults and halts instead of being word-aligned.
module ifu32
  import ifu32_pkg::*;
#(
  parameter int INST_MAX = 32,
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEF),
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [WIDTH-1:0]    imem_req_addr,
  input  logic                imem_rsp_valid,
  input  logic [INST_MAX-1:0] imem_rsp_data,
  input  logic                imem_rsp_err,
  input  logic                redirect_valid,
  input  logic [WIDTH-1:0]    redirect_pc,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [INST_MAX-1:0] inst,
  output logic [WIDTH-1:0]    inst_pc,
  output logic                fetch_fault
);
  localparam int PW = $clog2(DEPTH);
  state_e state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d, red_pc;
  logic fault_q, fault_d;
  logic [PW:0] count;
  logic [WIDTH+INST_MAX-1:0] q_dout;
  logic hs, push, pop, misalign, outstanding;
`ifdef IFU32_ALIGN_CHECK_EN
  assign misalign = redirect_pc[1:0] != 2'b00;
  assign red_pc = redirect_pc;
`else
  assign misalign = 1'b0;
  assign red_pc = {redirect_pc[WIDTH-1:2], 2'b00};
`endif
  // The queue only ever receives the single outstanding fetch, so a free slot at issue time stays free.
  assign imem_req_valid = state_q == S_REQ && count < (PW+1)'(DEPTH);
  assign imem_req_addr = pc_q;
  assign hs = imem_req_valid && imem_req_ready;
  assign push = state_q == S_WAIT && imem_rsp_valid && !imem_rsp_err && !redirect_valid;
  assign pop = inst_valid && inst_ready;
  // A redirect must discard a response that has not yet returned: either just issued or still in flight.
  assign outstanding = (state_q == S_REQ && hs) || ((state_q == S_WAIT || state_q == S_DROP) && !imem_rsp_valid);
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: state_d = hs ? S_WAIT : S_REQ;
      S_WAIT: if (imem_rsp_valid) begin
        state_d = imem_rsp_err ? S_HALT : S_REQ;
        fault_d = imem_rsp_err;
        pc_d = imem_rsp_err ? pc_q : pc_q + WIDTH'(PC_STEP);
      end
      S_DROP: state_d = imem_rsp_valid ? S_REQ : S_DROP;
      default: state_d = state_q;
    endcase
    if (redirect_valid) begin
      pc_d = red_pc;
      fault_d = misalign;
      state_d = misalign ? S_HALT : outstanding ? S_DROP : S_REQ;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      pc_q <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      fault_q <= fault_d;
    end
  ifu32_fifo #(.DW(WIDTH + INST_MAX), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(redirect_valid),
    .push(push),
    .din({pc_q, imem_rsp_data}),
    .pop(pop),
    .dout(q_dout),
    .count(count)
  );
  assign inst_valid = count != '0;
  assign inst = inst_valid ? q_dout[INST_MAX-1:0] : '0;
  assign inst_pc = inst_valid ? q_dout[WIDTH+INST_MAX-1 -: WIDTH] : '0;
  assign fetch_fault = fault_q;
endmodule

// File: tb/tb_ifu32.sv
// tb_ifu32: randomized fetch-stream bench with a memory responder and an in-order PC scoreboard
module tb_ifu32;
  logic clk = 1'b0;
  logic rst;
  logic imem_req_valid, imem_req_ready, imem_rsp_valid, imem_rsp_err;
  logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, inst, inst_pc;
  logic redirect_valid, inst_valid, inst_ready, fetch_fault;
  int n_vec = 0, n_err = 0;
  logic [31:0] exp_pc, exp_req, paddr, err_addr, prev_inst, prev_pc;
  bit pend, stale, exp_fault, exp_halt, chk_red, prev_stall, saw_zero_pc, saw_zero_req;
  int delay, lat, held, n_pop, rdy_pct, ir_pct, k;

  always #5 clk = ~clk;

  ifu32 dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .fetch_fault(fetch_fault)
  );

  function automatic logic [31:0] mf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_pc = 32'h8000_0000;
    exp_req = 32'h8000_0000;
    held = 0;
    stale = pend;
    exp_fault = 0;
    exp_halt = 0;
    chk_red = 0;
    prev_stall = 0;
  endtask

  // Called at the falling edge: checks this cycle's outputs, then records what the next rising edge does.
  task automatic observe();
    bit hs, pop, rv, mis;
    logic [31:0] t;
    chk("fault", {31'b0, fetch_fault}, {31'b0, exp_fault});
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, held != 0});
    if (exp_halt) chk("halt_noreq", {31'b0, imem_req_valid}, 32'd0);
    if (prev_stall) begin
      chk("stable_inst", inst, prev_inst);
      chk("stable_pc", inst_pc, prev_pc);
    end
    if (chk_red) begin
      chk("red_req_valid", {31'b0, imem_req_valid}, 32'd1);
      chk("red_req_addr", imem_req_addr, exp_req);
    end
    chk_red = 0;
    hs = imem_req_valid && imem_req_ready;
    pop = inst_valid && inst_ready;
    rv = imem_rsp_valid;
    if (pop) begin
      chk("inst_pc", inst_pc, exp_pc);
      chk("inst", inst, mf(exp_pc));
      if (inst_pc === 32'd0) saw_zero_pc = 1;
      exp_pc += 4;
      held--;
      n_pop++;
    end
    if (hs) begin
      chk("req_addr", imem_req_addr, exp_req);
      if (imem_req_addr === 32'd0) saw_zero_req = 1;
      exp_req += 4;
    end
    if (rv) begin
      if (!stale && !redirect_valid) begin
        if (imem_rsp_err) begin
          exp_fault = 1;
          exp_halt = 1;
        end else held++;
      end
      pend = 0;
    end
    if (hs) begin
      pend = 1;
      stale = 0;
      delay = lat;
      paddr = imem_req_addr;
    end
    prev_stall = inst_valid && !inst_ready && !redirect_valid;
    prev_inst = inst;
    prev_pc = inst_pc;
    if (redirect_valid) begin
      t = redirect_pc;
`ifdef IFU32_ALIGN_CHECK_EN
      mis = t[1:0] != 2'b00;
`else
      mis = 0;
      t[1:0] = 2'b00;
`endif
      held = 0;
      stale = pend;
      exp_pc = t;
      exp_req = t;
      exp_fault = mis;
      exp_halt = mis;
      chk_red = !mis && !pend;
    end
  endtask

  task automatic mem_drive();
    if (pend && delay == 0) begin
      imem_rsp_valid = 1;
      imem_rsp_data = mf(paddr);
      imem_rsp_err = paddr == err_addr;
    end else begin
      imem_rsp_valid = 0;
      imem_rsp_data = $urandom;
      imem_rsp_err = 1'($urandom_range(1));
      if (pend) delay--;
    end
    imem_req_ready = !pend && ($urandom_range(99) < rdy_pct);
    inst_ready = $urandom_range(99) < ir_pct;
  endtask

  task automatic cyc();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    redirect_valid = 0;
    mem_drive();
  endtask

  task automatic redir(input logic [31:0] t);
    redirect_valid = 1;
    redirect_pc = t;
    cyc();
  endtask

  task automatic wait_pend();
    for (int i = 0; i < 50 && !(pend && !stale); i++) cyc();
    if (!(pend && !stale)) begin
      n_vec++;
      n_err++;
      $error("FAIL wait_pend: no request accepted within 50 cycles");
    end
  endtask

  initial begin
    rst = 1;
    redirect_valid = 0;
    redirect_pc = 0;
    imem_req_ready = 0;
    imem_rsp_valid = 0;
    imem_rsp_data = 0;
    imem_rsp_err = 0;
    inst_ready = 0;
    pend = 0;
    delay = 0;
    paddr = 0;
    err_addr = 32'h1;
    lat = 0;
    rdy_pct = 100;
    ir_pct = 100;
    n_pop = 0;
    saw_zero_pc = 0;
    saw_zero_req = 0;
    prev_inst = 0;
    prev_pc = 0;
    model_reset();
    #3;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h8000_0000);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    @(posedge clk);
    #1;
    rst = 0;
    mem_drive();
    repeat (40) cyc();
    chk("steady_progress", {31'b0, n_pop >= 15}, 32'd1);
    ir_pct = 0;
    repeat (10) cyc();
    chk("stall_req_off", {31'b0, imem_req_valid}, 32'd0);
    chk("stall_inst_valid", {31'b0, inst_valid}, 32'd1);
    ir_pct = 100;
    repeat (10) cyc();
    lat = 2;
    wait_pend();
    k = n_pop;
    redir(32'h8000_0100);
    repeat (20) cyc();
    chk("redir_progress", {31'b0, n_pop > k}, 32'd1);
    lat = 0;
    err_addr = 32'h8000_0008;
    redir(32'h8000_0000);
    repeat (15) cyc();
    chk("err_fault", {31'b0, fetch_fault}, 32'd1);
    chk("err_noreq", {31'b0, imem_req_valid}, 32'd0);
    err_addr = 32'h1;
    k = n_pop;
    redir(32'h8000_0000);
    chk("fault_clear", {31'b0, fetch_fault}, 32'd0);
    repeat (10) cyc();
    chk("resume_progress", {31'b0, n_pop > k}, 32'd1);
    k = n_pop;
    redir(32'h8000_0102);
    repeat (10) cyc();
`ifdef IFU32_ALIGN_CHECK_EN
    chk("mis_fault", {31'b0, fetch_fault}, 32'd1);
    chk("mis_noreq", {31'b0, imem_req_valid}, 32'd0);
    redir(32'h8000_0200);
    repeat (10) cyc();
`else
    chk("mis_fault", {31'b0, fetch_fault}, 32'd0);
    chk("mis_progress", {31'b0, n_pop > k}, 32'd1);
`endif
    redir(32'hFFFF_FFF0);
    repeat (20) cyc();
    chk("wrap_req0", {31'b0, saw_zero_req}, 32'd1);
    chk("wrap_pc0", {31'b0, saw_zero_pc}, 32'd1);
    rdy_pct = 60;
    ir_pct = 70;
    err_addr = 32'h8000_0000 + ($urandom_range(63) << 2);
    for (int i = 0; i < 400; i++) begin
      lat = $urandom_range(2);
      if ($urandom_range(99) < 5 || (exp_halt && $urandom_range(99) < 20))
        redir((32'h8000_0000 + ($urandom_range(127) << 2)) | ($urandom_range(9) == 0 ? 32'($urandom_range(3)) : 32'd0));
      else cyc();
    end
    err_addr = 32'h1;
    rdy_pct = 100;
    ir_pct = 100;
    lat = 3;
    redir(32'h8000_0040);
    wait_pend();
    #2;
    rst = 1;
    #1;
    chk("arst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("arst_req_addr", imem_req_addr, 32'h8000_0000);
    chk("arst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("arst_fault", {31'b0, fetch_fault}, 32'd0);
    model_reset();
    repeat (3) cyc();
    rst = 0;
    k = n_pop;
    repeat (30) cyc();
    chk("arst_progress", {31'b0, n_pop > k}, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
